// File: rtl/bec_wb_sequencer.sv
// bec_wb_sequencer: Wishbone slave that loads the 163-bit operands of the BEC ladder core, starts it, feeds key bits and captures wout/zout.
// Latency: registered ack one cycle after a request, single-cycle pulse; write data lands on the ack edge, read data is valid with ack.
// Backpressure: none; every decoded request is acked, and a held strobe is acked on alternate cycles.
// Ports: wb_clk_i/wb_rst_i (async, active-high); wbs_* Wishbone slave; core_* operand, key-bit, enable and result handshake to the core; irq level interrupt.
// Optional feature: define BEC_WATCHDOG_EN to add a RUN-state watchdog (parameter WDOG_CYCLES) that reports STATUS.TIMEOUT.
module bec_wb_sequencer #(
  parameter int          FIELD_W   = 163,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          KEY_W     = 163
`ifdef BEC_WATCHDOG_EN
  , parameter int        WDOG_CYCLES = 200000
`endif
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               core_enable,
  output logic [FIELD_W-1:0] core_w1,
  output logic [FIELD_W-1:0] core_z1,
  output logic [FIELD_W-1:0] core_w2,
  output logic [FIELD_W-1:0] core_z2,
  output logic [FIELD_W-1:0] core_inv_w0,
  output logic [FIELD_W-1:0] core_d,
  output logic               core_ki,
  input  logic               core_next_key,
  input  logic [FIELD_W-1:0] core_wout,
  input  logic [FIELD_W-1:0] core_zout,
  input  logic               core_done,
  output logic               irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] KEYCNT_MAX = 8'(KEY_W);

  logic [1:0]         state;
  // op_q[0..5] = w1, z1, w2, z2, inv_w0, d; op_q[6] = key (shifts in place)
  logic [FIELD_W-1:0] op_q [7];
  logic [FIELD_W-1:0] wout_q, zout_q;
  logic               irq_en, st_done, st_err, st_to;
  logic [7:0]         keycnt;

  logic [4:0]         blk;
  logic [2:0]         wrd;
  logic [7:0]         reg_sel;
  logic               req, wr, busy, word_ok;
  logic               is_op, is_wout, is_zout, is_ctrl, is_status, is_keycnt;
  logic               start_req, go_run, done_evt, wdog_exp, end_run, err_set, w1c;
  logic [FIELD_W-1:0] wmask, wdata;
  logic [31:0]        rdata;
  logic               unused_adr;

  assign blk     = wbs_adr_i[9:5];
  assign wrd     = wbs_adr_i[4:2];
  assign reg_sel = wbs_adr_i[9:2];
  assign unused_adr = ^wbs_adr_i[1:0];

  // ~ack gating: a strobe held across the ack cycle must re-request
  assign req  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  assign wr   = req & wbs_we_i;
  assign busy = (state == ST_RUN);

  assign word_ok   = (wrd < 3'd6);
  assign is_op     = word_ok && (blk < 5'd7);
  assign is_wout   = word_ok && (blk == 5'd8);
  assign is_zout   = word_ok && (blk == 5'd9);
  assign is_ctrl   = (reg_sel == 8'h60);
  assign is_status = (reg_sel == 8'h61);
  assign is_keycnt = (reg_sel == 8'h62);

  assign start_req = wr & is_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
  assign go_run    = start_req & ~busy;
  assign done_evt  = busy & core_done;
  assign end_run   = done_evt | wdog_exp;
  assign err_set   = wr & busy & (is_op | (is_ctrl & wbs_sel_i[0] & wbs_dat_i[0]));
  assign w1c       = wr & is_status;

  // Byte-lane merge; bits beyond FIELD_W fall off the top of the shift
  assign wmask = FIELD_W'({{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}}) << {wrd, 5'd0};
  assign wdata = FIELD_W'(wbs_dat_i) << {wrd, 5'd0};

  function automatic logic [31:0] word_of(input logic [FIELD_W-1:0] f, input logic [2:0] k);
    return 32'(f >> {k, 5'd0});
  endfunction

  always_comb begin
    rdata = 32'd0;
    if (is_op)          rdata = word_of(op_q[blk[2:0]], wrd);
    else if (is_wout)   rdata = word_of(wout_q, wrd);
    else if (is_zout)   rdata = word_of(zout_q, wrd);
    else if (is_ctrl)   rdata = {30'd0, irq_en, 1'b0};
    else if (is_status) rdata = {28'd0, st_to, st_err, st_done, busy};
    else if (is_keycnt) rdata = {24'd0, keycnt};
  end

`ifdef BEC_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)    wdog_cnt <= 32'd0;
    else if (go_run) wdog_cnt <= 32'd0;
    else if (busy)   wdog_cnt <= wdog_cnt + 32'd1;
  end
  // Expiry at the end of the WDOG_CYCLES-th RUN cycle; a same-cycle done wins
  assign wdog_exp = busy & ~core_done & (wdog_cnt == 32'(WDOG_CYCLES - 1));
`else
  assign wdog_exp = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      for (int i = 0; i < 7; i++) op_q[i] <= '0;
      wout_q    <= '0;
      zout_q    <= '0;
      irq_en    <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      st_to     <= 1'b0;
      keycnt    <= 8'd0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rdata : 32'd0;

      for (int i = 0; i < 7; i++)
        if (wr & is_op & ~busy & (blk[2:0] == 3'(i)))
          op_q[i] <= (op_q[i] & ~wmask) | (wdata & wmask);
      // Key writes are blocked in RUN, so the shift never collides with a write
      if (busy & core_next_key) op_q[6] <= op_q[6] >> 1;

      if (wr & is_ctrl & wbs_sel_i[0]) irq_en <= wbs_dat_i[1];

      if (go_run) keycnt <= 8'd0;
      else if (busy & core_next_key & (keycnt != KEYCNT_MAX)) keycnt <= keycnt + 8'd1;

      if (done_evt) begin
        wout_q <= core_wout;
        zout_q <= core_zout;
      end

      // Set has priority over W1C for every status flag
      if (done_evt)                          st_done <= 1'b1;
      else if (go_run | (w1c & wbs_dat_i[1])) st_done <= 1'b0;
      if (err_set)                           st_err  <= 1'b1;
      else if (w1c & wbs_dat_i[2])           st_err  <= 1'b0;
      if (wdog_exp)                          st_to   <= 1'b1;
      else if (w1c & wbs_dat_i[3])           st_to   <= 1'b0;

      case (state)
        ST_IDLE: if (go_run) state <= ST_RUN;
        ST_RUN:  if (end_run) state <= ST_DONE;
        ST_DONE: begin
          if (go_run)                     state <= ST_RUN;
          else if (w1c & wbs_dat_i[1])    state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign core_enable = busy;
  assign core_w1     = op_q[0];
  assign core_z1     = op_q[1];
  assign core_w2     = op_q[2];
  assign core_z2     = op_q[3];
  assign core_inv_w0 = op_q[4];
  assign core_d      = op_q[5];
  assign core_ki     = op_q[6][0];
  assign irq         = irq_en & (st_done | st_to);

endmodule

// File: tb/tb_bec_wb_sequencer.sv
// tb_bec_wb_sequencer: randomized bus and core-event stimulus checked against a register-map level model.
// Latency: drives one Wishbone request at a time and expects ack on the following cycle.
// Backpressure: none modelled; the core model pulses next_key/done directly.
module tb_bec_wb_sequencer;
  localparam int          FW   = 163;
  localparam int          KW   = 163;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef BEC_WATCHDOG_EN
  localparam int          TB_WDOG = 400;
`endif

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [31:0]   wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          core_enable, core_ki, irq;
  logic [FW-1:0] core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d;
  logic          core_next_key = 1'b0, core_done = 1'b0;
  logic [FW-1:0] core_wout = '0, core_zout = '0;

  always #5 wb_clk_i = ~wb_clk_i;

`ifdef BEC_WATCHDOG_EN
  bec_wb_sequencer #(.WDOG_CYCLES(TB_WDOG)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_enable(core_enable),
    .core_w1(core_w1), .core_z1(core_z1), .core_w2(core_w2), .core_z2(core_z2),
    .core_inv_w0(core_inv_w0), .core_d(core_d),
    .core_ki(core_ki), .core_next_key(core_next_key),
    .core_wout(core_wout), .core_zout(core_zout), .core_done(core_done),
    .irq(irq)
  );
`else
  bec_wb_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_enable(core_enable),
    .core_w1(core_w1), .core_z1(core_z1), .core_w2(core_w2), .core_z2(core_z2),
    .core_inv_w0(core_inv_w0), .core_d(core_d),
    .core_ki(core_ki), .core_next_key(core_next_key),
    .core_wout(core_wout), .core_zout(core_zout), .core_done(core_done),
    .irq(irq)
  );
`endif

  // Reference model: register contents and flags, no notion of DUT encoding
  logic [FW-1:0] m_op [7];
  logic [FW-1:0] m_wout, m_zout;
  bit            m_run, m_done, m_err, m_to, m_irqen;
  int            m_kcnt;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 7; i++) m_op[i] = '0;
    m_wout = '0; m_zout = '0;
    m_run = 0; m_done = 0; m_err = 0; m_to = 0; m_irqen = 0; m_kcnt = 0;
  endtask

  function automatic logic [FW-1:0] rand_field();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[FW-1:0];
  endfunction

  function automatic logic [31:0] fword(input logic [FW-1:0] f, input int k);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++)
      if (32 * k + i < FW) w[i] = f[32 * k + i];
    return w;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int off = int'(a[9:0]);
    int blk = off / 32;
    int k = (off % 32) / 4;
    if (k < 6 && blk < 7)  return fword(m_op[blk], k);
    if (k < 6 && blk == 8) return fword(m_wout, k);
    if (k < 6 && blk == 9) return fword(m_zout, k);
    if (off / 4 == 'h60)   return {30'd0, m_irqen, 1'b0};
    if (off / 4 == 'h61)   return {28'd0, m_to, m_err, m_done, m_run};
    if (off / 4 == 'h62)   return 32'(m_kcnt);
    return 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int off = int'(a[9:0]);
    int blk = off / 32;
    int k = (off % 32) / 4;
    if (k < 6 && blk < 7) begin
      if (m_run) m_err = 1;
      else for (int i = 0; i < 32; i++)
        if (s[i / 8] && 32 * k + i < FW) m_op[blk][32 * k + i] = d[i];
    end else if (off / 4 == 'h60) begin
      if (s[0]) begin
        m_irqen = d[1];
        if (d[0]) begin
          if (m_run) m_err = 1;
          else begin m_run = 1; m_done = 0; m_kcnt = 0; end
        end
      end
    end else if (off / 4 == 'h61) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
      if (d[3]) m_to = 0;
    end
  endtask

  task automatic check_outputs();
    check("core_w1", core_w1, m_op[0]);
    check("core_z1", core_z1, m_op[1]);
    check("core_w2", core_w2, m_op[2]);
    check("core_z2", core_z2, m_op[3]);
    check("core_inv_w0", core_inv_w0, m_op[4]);
    check("core_d", core_d, m_op[5]);
    check("core_ki", core_ki, m_op[6][0]);
    check("core_enable", core_enable, m_run);
    check("irq", irq, m_irqen & (m_done | m_to));
  endtask

  // Called at #1 after a clock edge; returns at #1 after the cycle following ack
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    bit hit = (a[31:10] == BASE[31:10]);
    logic [31:0] e = m_read(a);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = w; wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    r = wbs_dat_o;
    check($sformatf("ack_%0h", a), wbs_ack_o, hit);
    if (hit && w) model_write(a, d, s);
    if (hit && !w) check($sformatf("rd_%0h", a[9:0]), r, e);
    check_outputs();
    @(posedge wb_clk_i); #1;
    check("ack_one_cycle", wbs_ack_o, 1'b0);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, s, r);
  endtask

  task automatic wb_rd(input logic [31:0] a);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'd0, 4'hF, r);
  endtask

  task automatic core_evt(input bit nk, input bit dn, input logic [FW-1:0] wo, input logic [FW-1:0] zo);
    core_next_key = nk; core_done = dn; core_wout = wo; core_zout = zo;
    @(posedge wb_clk_i); #1;
    core_next_key = 0; core_done = 0;
    if (m_run) begin
      if (nk) begin
        m_op[6] = m_op[6] >> 1;
        if (m_kcnt < KW) m_kcnt++;
      end
      if (dn) begin
        m_wout = wo; m_zout = zo; m_done = 1; m_run = 0;
      end
    end
    check_outputs();
  endtask

  initial begin
    logic [FW-1:0] exp_w1;
    logic [31:0]   r, a, d;
    m_reset();
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", wbs_ack_o, 1'b0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check_outputs();
    wb_rst_i = 0;
    @(posedge wb_clk_i); #1;
    wb_rd(BASE + 32'h180); wb_rd(BASE + 32'h184); wb_rd(BASE + 32'h188); wb_rd(BASE + 32'h100);

    // w1 fill: top word keeps only bits [2:0]
    for (int k = 0; k < 5; k++) wb_wr(BASE + 32'(4 * k), 32'h1111_1111, 4'hF);
    wb_wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    exp_w1 = {3'b111, {5{32'h1111_1111}}};
    check("w1_pattern", core_w1, exp_w1);
    wb_xfer(1'b0, BASE + 32'h14, 32'd0, 4'hF, r);
    check("w1_word5", r, 32'h7);

    // Held strobe: acks on alternate cycles only
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h180; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1; check("held_ack0", wbs_ack_o, 1'b1);
    @(posedge wb_clk_i); #1; check("held_ack1", wbs_ack_o, 1'b0);
    @(posedge wb_clk_i); #1; check("held_ack2", wbs_ack_o, 1'b1);
    wbs_stb_i = 0; wbs_cyc_i = 0;
    @(posedge wb_clk_i); #1; check("held_ack3", wbs_ack_o, 1'b0);

    // Random register traffic in IDLE (START masked off)
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 2) a = 32'($urandom_range(0, 7) * 32 + $urandom_range(0, 7) * 4);
      else a = 32'($urandom_range(0, 255) * 4);
      d = $urandom();
      if (a == 32'h180) d[0] = 1'b0;
      a = (($urandom % 8) == 0) ? (32'h4000_0000 | a) : (BASE | a);
      if ($urandom % 2) wb_wr(a, d, 4'($urandom_range(0, 15)));
      else wb_rd(a);
    end

    // Ladder runs: key load, start, key shifts, busy errors, done capture
    for (int run = 0; run < 4; run++) begin
      logic [FW-1:0] key;
      key = (run == 0) ? FW'(5) : rand_field();
      for (int k = 0; k < 6; k++) wb_wr(BASE + 32'h0C0 + 32'(4 * k), fword(key, k), 4'hF);
      wb_wr(BASE + 32'h180, (run == 0) ? 32'h3 : 32'(2 * ($urandom % 2) + 1), 4'hF);
      if (run == 3) for (int p = 0; p < 170; p++) core_evt(1'b1, 1'b0, '0, '0);
      else begin
        int n = (run == 0) ? 3 : $urandom_range(0, 8);
        for (int p = 0; p < n; p++) begin
          core_evt(1'b1, 1'b0, '0, '0);
          if ($urandom % 2) core_evt(1'b0, 1'b0, '0, '0);
        end
      end
      wb_rd(BASE + 32'h188);
      wb_rd(BASE + 32'h184);
      wb_wr(BASE + 32'h060, $urandom(), 4'hF);
      wb_rd(BASE + 32'h184);
      wb_wr(BASE + 32'h180, {$urandom_range(0, 1) == 1 ? 30'd1 : 30'd0, 2'b01}, 4'hF);
      wb_rd(BASE + 32'h184);
      wb_wr(BASE + 32'h184, 32'h4, 4'hF);
      core_evt(1'($urandom % 2), 1'b1, (run == 0) ? FW'(12'hABC) : rand_field(), rand_field());
      for (int k = 0; k < 6; k++) begin
        wb_rd(BASE + 32'h100 + 32'(4 * k));
        wb_rd(BASE + 32'h120 + 32'(4 * k));
      end
      wb_rd(BASE + 32'h184);
      if (run % 2 == 0) wb_wr(BASE + 32'h184, 32'h2, 4'hF);
    end

    // Core events outside RUN are ignored
    core_evt(1'b1, 1'b1, rand_field(), rand_field());
    wb_rd(BASE + 32'h100); wb_rd(BASE + 32'h188); wb_rd(BASE + 32'h184);
    wb_wr(BASE + 32'h184, 32'h2, 4'hF);

    // Reset in the middle of a run
    wb_wr(BASE + 32'h180, 32'h3, 4'hF);
    core_evt(1'b1, 1'b0, '0, '0);
    wb_rst_i = 1;
    #1;
    check("rst_async_enable", core_enable, 1'b0);
    m_reset();
    @(posedge wb_clk_i); #1;
    wb_rst_i = 0;
    check_outputs();
    for (int k = 0; k < 6; k++) begin
      wb_rd(BASE + 32'h000 + 32'(4 * k)); wb_rd(BASE + 32'h0C0 + 32'(4 * k));
      wb_rd(BASE + 32'h100 + 32'(4 * k)); wb_rd(BASE + 32'h120 + 32'(4 * k));
    end
    wb_rd(BASE + 32'h180); wb_rd(BASE + 32'h184); wb_rd(BASE + 32'h188);

`ifdef BEC_WATCHDOG_EN
    // No done: expiry lands on the last edge of the TB_WDOG-th RUN cycle
    wb_wr(BASE + 32'h180, 32'h3, 4'hF);
    repeat (TB_WDOG - 2) @(posedge wb_clk_i);
    #1;
    check("wdog_pre_enable", core_enable, 1'b1);
    check("wdog_pre_irq", irq, 1'b0);
    @(posedge wb_clk_i); #1;
    m_run = 0; m_to = 1;
    check_outputs();
    wb_rd(BASE + 32'h184);
    wb_wr(BASE + 32'h184, 32'h8, 4'hF);
    wb_wr(BASE + 32'h184, 32'h2, 4'hF);
    wb_rd(BASE + 32'h184);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
